// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: bit-serial add/subtract sequencer, LSB-first through a 1-bit cell with registered carry
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q, c_q, c_msb;
    logic [CW-1:0]    cnt;
    logic             bx, s, c_nxt, last, accept;

    // one-bit add/sub cell plus FSM next-state and status decode; RUN spends WIDTH bit cycles and one cycle latching flags
    always_comb begin
        bx        = b_q[0] ^ sub_q;
        s         = a_q[0] ^ bx ^ c_q;
        c_nxt     = (a_q[0] & bx) | ((a_q[0] | bx) & c_q);
        last      = cnt == CW'(WIDTH);
        accept    = state == IDLE && start;
        busy      = state == RUN;
        done      = state == DONE;
        state_nxt = state;
        if (state == IDLE && start)
            state_nxt = RUN;
        else if (state == RUN && last)
            state_nxt = DONE;
        else if (state == DONE)
            state_nxt = IDLE;
    end

    // state register, operand capture, bit-serial shifting and flag latching
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            c_q       <= 1'b0;
            c_msb     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                sub_q <= sub;
                c_q   <= sub;
                cnt   <= '0;
            end else if (state == RUN && !last) begin
                a_q    <= a_q >> 1;
                b_q    <= b_q >> 1;
                result <= {s, result[WIDTH-1:1]};
                c_q    <= c_nxt;
                c_msb  <= cnt == CW'(WIDTH - 1) ? c_q : c_msb;
                cnt    <= cnt + CW'(1);
            end else if (state == RUN) begin
                carry_out <= c_q;
                overflow  <= c_msb ^ c_q;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: directed table-driven bench for the bit-serial add/sub sequencer
module tb_serial_addsub_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .sub(sub),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= W + 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        launch(v.a, v.b, v.s);
        check({name, " busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({name, " latency"}, 32'(n), 32'(W + 1));
        check({name, " result"}, 32'(result), 32'(v.r));
        check({name, " carry"}, 32'(carry_out), 32'(v.co));
        check({name, " ovf"}, 32'(overflow), 32'(v.ov));
        @(posedge clk);
        #1;
        check({name, " pulse"}, {30'd0, done, busy}, 32'd0);
        check({name, " hold"}, {23'd0, result, carry_out}, {23'd0, v.r, v.co});
    endtask

    initial begin
        int n;
        int cnt;
        logic [W-1:0] r;
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {20'd0, busy, done, result, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // restart while running: ignored, one done, original result
        launch(8'h35, 8'h4A, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        r   = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt++;
                r = result;
            end
        end
        check("ignored start dones", 32'(cnt), 32'd1);
        check("ignored start result", 32'(r), 32'h7F);

        // reset mid-run: outputs cleared, no done pulse
        launch(8'h7F, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", {20'd0, busy, done, result, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) cnt++;
        end
        check("abort no done", 32'(cnt), 32'd0);
        run_vec(vecs[1], "after abort");

        // reset and start together: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst beats start", {20'd0, busy, done, result, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst beats start idle", 32'(busy), 32'd0);
        run_vec(vecs[4], "after rst+start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
